// File: rtl/ram_arb_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : ram_arb_pkg
// Brief  : Shared types, widths and byte-lane helpers for the RAM arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package ram_arb_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_ADDR = 3'd2,
    RD_DATA = 3'd3,
    RMW_WR  = 3'd4,
    RESP    = 3'd5
  } state_t;

  // Replace the byte lane chosen by sel, leaving the other three untouched.
  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [7:0]  byt,
                                             input logic [1:0]  sel);
    logic [31:0] r;
    r = word;
    case (sel)
      2'd0: r[7:0]   = byt;
      2'd1: r[15:8]  = byt;
      2'd2: r[23:16] = byt;
      2'd3: r[31:24] = byt;
      default: r = word;
    endcase
    return r;
  endfunction

  // Pull the byte lane chosen by sel down to bits [7:0], zero-extended.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  sel);
    logic [7:0] b;
    case (sel)
      2'd0: b = word[7:0];
      2'd1: b = word[15:8];
      2'd2: b = word[23:16];
      2'd3: b = word[31:24];
      default: b = word[7:0];
    endcase
    return {24'h0, b};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_arb_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : ram_arb_ctrl_if
// Brief  : Request/acknowledge bundle for the two RAM requesters.
// Rev    : 1.0  initial release
// ============================================================================
interface ram_arb_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              Req0, Req1;
  logic              Wr0, Wr1;
  logic              Size0, Size1;
  logic [ADDR_W-1:0] Addr0, Addr1;
  logic [DATA_W-1:0] WData0, WData1;
  logic              Ack0, Ack1;
  logic [DATA_W-1:0] RData0, RData1;

  modport master (
    output Req0, Wr0, Size0, Addr0, WData0,
    output Req1, Wr1, Size1, Addr1, WData1,
    input  Ack0, RData0, Ack1, RData1
  );

  modport slave (
    input  Req0, Wr0, Size0, Addr0, WData0,
    input  Req1, Wr1, Size1, Addr1, WData1,
    output Ack0, RData0, Ack1, RData1
  );
endinterface
`default_nettype wire

// File: rtl/ram_arb_ctrl_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module : rr_arb2
// Brief  : Two-way round-robin grant; pointer moves past the served requester.
// Rev    : 1.0  initial release
// ============================================================================
module rr_arb2 (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic req0,
  input  wire logic req1,
  input  wire logic upd,
  input  wire logic upd_id,
  output logic      gnt_valid,
  output logic      gnt_id
);
  logic ptr_q, ptr_d;

  // After a completed request, priority passes to the other requester.
  always_comb begin
    ptr_d = ptr_q;
    if (upd) ptr_d = ~upd_id;
  end

  // Pointer register, requester 0 favoured out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

  // A lone request wins outright; a tie is settled by the pointer.
  always_comb begin
    gnt_valid = req0 | req1;
    gnt_id    = 1'b0;
    if (req0 && req1) gnt_id = ptr_q;
    else if (req1)    gnt_id = 1'b1;
  end
endmodule
`default_nettype wire

// File: rtl/ram_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module : ram_arb_ctrl
// Brief  : Arbitrates two requesters onto a 64x32 single-port RAM, sequencing
//          word/byte reads and writes (byte stores via read-modify-write).
// Rev    : 1.0  initial release
// ============================================================================
module ram_arb_ctrl #(
  parameter int ADDR_W = ram_arb_pkg::ADDR_W,
  parameter int DATA_W = ram_arb_pkg::DATA_W
) (
  input  wire logic              Clk_m,
  input  wire logic              Rst_m,
  ram_arb_ctrl_if.slave          bus,
  output logic                   Busy,
  output logic                   ram_wea,
  output logic [ADDR_W-3:0]      ram_addr,
  output logic [DATA_W-1:0]      ram_dina,
  input  wire logic [DATA_W-1:0] ram_douta
);
  import ram_arb_pkg::*;

  state_t            state_q, state_d;
  logic              gid_q, gid_d;
  logic              wr_q, wr_d;
  logic              size_q, size_d;
  logic [1:0]        lane_q, lane_d;
  logic [7:0]        wbyte_q, wbyte_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              busy_q, busy_d;
  logic              wea_q, wea_d;
  logic [ADDR_W-3:0] addr_q, addr_d;
  logic [DATA_W-1:0] dina_q, dina_d;

  logic              gnt_valid, gnt_id;
  logic              sel_wr, sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata, rd_word;

  rr_arb2 u_arb (
    .clk      (Clk_m),
    .rst      (Rst_m),
    .req0     (bus.Req0),
    .req1     (bus.Req1),
    .upd      (state_q == RESP),
    .upd_id   (gid_q),
    .gnt_valid(gnt_valid),
    .gnt_id   (gnt_id)
  );

  // Fields of whichever requester the arbiter is currently favouring.
  always_comb begin
    sel_wr    = gnt_id ? bus.Wr1    : bus.Wr0;
    sel_size  = gnt_id ? bus.Size1  : bus.Size0;
    sel_addr  = gnt_id ? bus.Addr1  : bus.Addr0;
    sel_wdata = gnt_id ? bus.WData1 : bus.WData0;
    rd_word   = (size_q == SIZE_WORD) ? ram_douta : lane_extract(ram_douta, lane_q);
  end

  // Sequencer: next state plus next value of every registered output.
  always_comb begin
    state_d  = state_q;
    gid_d    = gid_q;
    wr_d     = wr_q;
    size_d   = size_q;
    lane_d   = lane_q;
    wbyte_d  = wbyte_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    addr_d   = addr_q;
    dina_d   = dina_q;
    wea_d    = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          gid_d   = gnt_id;
          wr_d    = sel_wr;
          size_d  = sel_size;
          lane_d  = sel_addr[1:0];
          wbyte_d = sel_wdata[7:0];
          addr_d  = sel_addr[ADDR_W-1:2];
          if (sel_wr && sel_size == SIZE_WORD) begin
            state_d = WR;
            wea_d   = 1'b1;
            dina_d  = sel_wdata;
          end else begin
            state_d = RD_ADDR;
          end
        end
      end
      WR:      state_d = RESP;
      RD_ADDR: state_d = RD_DATA;
      RD_DATA: begin
        // RAM word is valid now: either merge it for a byte store or return it.
        if (wr_q) begin
          state_d = RMW_WR;
          wea_d   = 1'b1;
          dina_d  = lane_merge(ram_douta, wbyte_q, lane_q);
        end else begin
          state_d = RESP;
          if (gid_q) rdata1_d = rd_word;
          else       rdata0_d = rd_word;
        end
      end
      RMW_WR:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == RESP && state_q != RESP) begin
      ack0_d = ~gid_q;
      ack1_d = gid_q;
    end
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge Clk_m or posedge Rst_m) begin
    if (Rst_m) begin
      state_q  <= IDLE;
      gid_q    <= 1'b0;
      wr_q     <= 1'b0;
      size_q   <= 1'b0;
      lane_q   <= 2'd0;
      wbyte_q  <= 8'd0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      busy_q   <= 1'b0;
      wea_q    <= 1'b0;
      addr_q   <= '0;
      dina_q   <= '0;
    end else begin
      state_q  <= state_d;
      gid_q    <= gid_d;
      wr_q     <= wr_d;
      size_q   <= size_d;
      lane_q   <= lane_d;
      wbyte_q  <= wbyte_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      busy_q   <= busy_d;
      wea_q    <= wea_d;
      addr_q   <= addr_d;
      dina_q   <= dina_d;
    end
  end

  assign bus.Ack0   = ack0_q;
  assign bus.Ack1   = ack1_q;
  assign bus.RData0 = rdata0_q;
  assign bus.RData1 = rdata1_q;
  assign Busy       = busy_q;
  assign ram_wea    = wea_q;
  assign ram_addr   = addr_q;
  assign ram_dina   = dina_q;
endmodule
`default_nettype wire
